bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 16 +
 rtl/bus_arbiter_hold_timer.sv | 40 ++++
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter slice: master count, index width,
// FSM state type and the default grant-hold limit.
package bus_arbiter_pkg;

    localparam int NUM_MASTERS            = 8;
    localparam int IDX_W                  = 3;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int HOLD_CNT_W             = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_hold_timer.sv
// arb_hold_timer: counts cycles a grant has been held and flags when the
// configured limit is reached. Used only when BUS_ARBITER_TIMEOUT_EN is defined.
module arb_hold_timer
    import bus_arbiter_pkg::*;
#(
    parameter int CNT_W = HOLD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // count_reg holds the number of completed grant cycles before the current
    // one, so the limit is reached when the cycle now in progress is number 'limit'.
    assign expired = ((CNT_W+1)'(count_reg) + (CNT_W+1)'(1)) >= (CNT_W+1)'(limit);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && !expired) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule : arb_hold_timer

// File: rtl/bus_arbiter.sv
// Non-preemptive 8-master bus arbiter fed by an external priority encoder.
// Optional grant-hold timeout with master masking under BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] req_masked,
    input  logic [IDX_W:0]         enc,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic                   gnt_valid,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   timeout_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    arb_state_t             state_reg, state_next;
    logic [IDX_W-1:0]       owner_reg, owner_next;
    logic [NUM_MASTERS-1:0] gnt_reg, gnt_next;
    logic                   gnt_valid_reg, gnt_valid_next;
    logic [IDX_W-1:0]       gnt_idx_reg, gnt_idx_next;
    logic                   timeout_err_reg, timeout_err_next;

    logic [NUM_MASTERS-1:0] enc_onehot;
    logic [NUM_MASTERS-1:0] owner_onehot;
    logic                   enc_hit;
    logic                   owner_req;
    logic                   timer_expired;
    logic                   timeout_fire;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_decode
        assign enc_onehot[gi]   = (enc[IDX_W-1:0] == IDX_W'(gi));
        assign owner_onehot[gi] = (owner_reg == IDX_W'(gi));
    end

    // The encoding is only trusted if the indexed master is still requesting
    // (and not masked); a stale encoder output must not produce a grant.
    assign enc_hit      = enc[IDX_W] && |(enc_onehot & req_masked);
    assign owner_req    = |(owner_onehot & req);
    assign timeout_fire = (state_reg == ST_GRANT) && owner_req && timer_expired;

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [NUM_MASTERS-1:0] mask_reg;
    logic [NUM_MASTERS-1:0] mask_next;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
        assign mask_next[gi] = (mask_reg[gi] & req[gi]) | (timeout_fire & owner_onehot[gi]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_reg <= '0;
        end else begin
            mask_reg <= mask_next;
        end
    end

    assign req_masked = req & ~mask_reg;

    arb_hold_timer #(
        .CNT_W (HOLD_CNT_W)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_reg != ST_GRANT),
        .enable  (state_reg == ST_GRANT),
        .limit   (HOLD_CNT_W'(TIMEOUT_CYCLES)),
        .expired (timer_expired)
    );
`else
    assign req_masked    = req;
    assign timer_expired = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        owner_next       = owner_reg;
        gnt_next         = gnt_reg;
        gnt_valid_next   = gnt_valid_reg;
        gnt_idx_next     = gnt_idx_reg;
        timeout_err_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (enc_hit) begin
                    state_next     = ST_GRANT;
                    owner_next     = enc[IDX_W-1:0];
                    gnt_next       = enc_onehot;
                    gnt_valid_next = 1'b1;
                    gnt_idx_next   = enc[IDX_W-1:0];
                end
            end
            ST_GRANT: begin
                if (!owner_req || timeout_fire) begin
                    state_next       = ST_RELEASE;
                    gnt_next         = '0;
                    gnt_valid_next   = 1'b0;
                    gnt_idx_next     = '0;
                    timeout_err_next = timeout_fire;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next     = ST_IDLE;
                gnt_next       = '0;
                gnt_valid_next = 1'b0;
                gnt_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            owner_reg       <= '0;
            gnt_reg         <= '0;
            gnt_valid_reg   <= 1'b0;
            gnt_idx_reg     <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            gnt_reg         <= gnt_next;
            gnt_valid_reg   <= gnt_valid_next;
            gnt_idx_reg     <= gnt_idx_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign gnt         = gnt_reg;
    assign gnt_valid   = gnt_valid_reg;
    assign gnt_idx     = gnt_idx_reg;
    assign timeout_err = timeout_err_reg;

endmodule : bus_arbiter
